// File: rtl/mul_final_adder.sv
// Final carry-propagate adder of the multiplier: result = s_vec + (c_vec << 1) + cin0, split over
// two pipeline stages with valid/ready on both sides. Optional synchronous flush via MUL_FLUSH_EN.
`timescale 1ns/1ps
module mul_final_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SPLIT = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUL_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_vec,
  input  logic [WIDTH-1:0] c_vec,
  input  logic             cin0,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned HI_W = WIDTH - SPLIT;

  if (SPLIT < 1 || SPLIT >= WIDTH) begin : g_bad_split
    $error("mul_final_adder: SPLIT must satisfy 1 <= SPLIT < WIDTH");
  end

  logic             flush_req;
`ifdef MUL_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Stage 1 registers
  logic             s1_valid;
  logic [SPLIT-1:0] lo_sum;
  logic             lo_carry;
  logic [HI_W-1:0]  hi_s;
  logic [HI_W-1:0]  hi_c;
  logic [TAG_W-1:0] s1_tag;

  logic [WIDTH-1:0] c_sh;
  logic [SPLIT:0]   lo_full;
  logic [HI_W-1:0]  hi_sum;
  logic             s2_adv;
  logic             accept;
  logic             unused_c_msb;

  // c_vec[i] weights column i+1; the top carry falls off the product and is dropped.
  assign c_sh         = {c_vec[WIDTH-2:0], 1'b0};
  assign unused_c_msb = c_vec[WIDTH-1];

  assign lo_full = {1'b0, s_vec[SPLIT-1:0]} + {1'b0, c_sh[SPLIT-1:0]} + (SPLIT+1)'(cin0);
  assign hi_sum  = hi_s + hi_c + HI_W'(lo_carry);

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = (!s1_valid || s2_adv) && !flush_req;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      lo_sum    <= '0;
      lo_carry  <= 1'b0;
      hi_s      <= '0;
      hi_c      <= '0;
      s1_tag    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (flush_req) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= 1'b1;
        result    <= {hi_sum, lo_sum};
        out_tag   <= s1_tag;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        s1_valid <= 1'b1;
        lo_sum   <= lo_full[SPLIT-1:0];
        lo_carry <= lo_full[SPLIT];
        hi_s     <= s_vec[WIDTH-1:SPLIT];
        hi_c     <= c_sh[WIDTH-1:SPLIT];
        s1_tag   <= in_tag;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule
